// File: rtl/barrel_arbiter_pkg.sv
// Shared shift-type encoding, direction constants and width helper for barrel_arbiter.
package barrel_arbiter_pkg;

  localparam logic [1:0] SH_TYPE_ROT = 2'd0;  // rotate
  localparam logic [1:0] SH_TYPE_LOG = 2'd1;  // logical, zero fill
  localparam logic [1:0] SH_TYPE_ARI = 2'd2;  // arithmetic right, logical left
  localparam logic [1:0] SH_TYPE_RSV = 2'd3;  // behaves as logical

  localparam logic SH_LEFT  = 1'b1;
  localparam logic SH_RIGHT = 1'b0;

  function automatic int unsigned count_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/barrel.sv
// Combinational barrel shifter: rotate, logical and arithmetic shifts in either direction.
module barrel
  import barrel_arbiter_pkg::*;
#(
  parameter int unsigned width = 32,
  localparam int unsigned CW = count_width(width)
) (
  input  logic [width-1:0] data_i,
  input  logic [CW-1:0]    count_i,
  input  logic             left_i,
  input  logic [1:0]       sh_type_i,
  output logic [width-1:0] result_o
);

  logic [2*width-1:0] rot_l, rot_r;

  always_comb begin
    // Doubled operand turns a rotate into a plain shift plus slice.
    rot_l    = {data_i, data_i} << count_i;
    rot_r    = {data_i, data_i} >> count_i;
    result_o = data_i;
    if (left_i == SH_LEFT) begin
      if (sh_type_i == SH_TYPE_ROT) result_o = rot_l[2*width-1 -: width];
      else                          result_o = data_i << count_i;
    end else begin
      case (sh_type_i)
        SH_TYPE_ROT: result_o = rot_r[width-1:0];
        SH_TYPE_ARI: result_o = $unsigned($signed(data_i) >>> count_i);
        default:     result_o = data_i >> count_i;
      endcase
    end
  end

endmodule

// File: rtl/barrel_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping N-1 -> 0.
module rr_picker #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      j = (int'(ptr_i) + k) % int'(N);
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = IW'(j);
      end
    end
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/barrel_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NREQ requesters with a one-entry result reg.
// Optional BARREL_ARB_LOCK_EN adds req_lock so a granted requester can keep priority.
module barrel_arbiter
  import barrel_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned CW = count_width(WIDTH),
  localparam int unsigned IW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*CW-1:0]   req_count,
  input  logic [NREQ-1:0]      req_left,
  input  logic [NREQ*2-1:0]    req_type,
`ifdef BARREL_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_data,
  output logic [IW-1:0]        resp_id
);

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             accept, grant, lock_win;
  logic [WIDTH-1:0] sel_data, shift_res;
  logic [CW-1:0]    sel_count;
  logic             sel_left;
  logic [1:0]       sel_type;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic [IW-1:0]    resp_id_q, resp_id_d;

  rr_picker #(.N(NREQ)) u_picker (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel_data  = req_data[pick_idx*WIDTH +: WIDTH];
    sel_count = req_count[pick_idx*CW +: CW];
    sel_left  = req_left[pick_idx];
    sel_type  = req_type[pick_idx*2 +: 2];
  end

  barrel #(.width(WIDTH)) u_barrel (
    .data_i    (sel_data),
    .count_i   (sel_count),
    .left_i    (sel_left),
    .sh_type_i (sel_type),
    .result_o  (shift_res)
  );

`ifdef BARREL_ARB_LOCK_EN
  assign lock_win = req_lock[pick_idx];
`else
  assign lock_win = 1'b0;
`endif

  assign accept    = !resp_valid_q || resp_ready;
  assign grant     = accept && pick_any;
  assign req_ready = (grant && !rst) ? pick_gnt : '0;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    ptr_d        = ptr_q;
    // An empty or draining register takes the new winner, or empties if nobody asks.
    if (accept) resp_valid_d = pick_any;
    if (grant) begin
      resp_data_d = shift_res;
      resp_id_d   = pick_idx;
      if (lock_win)                          ptr_d = pick_idx;
      else if (pick_idx == IW'(NREQ - 1))    ptr_d = '0;
      else                                   ptr_d = pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      ptr_q        <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      ptr_q        <= ptr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_barrel_arbiter.sv
// Scoreboard bench for barrel_arbiter: directed cases plus randomized traffic vs a behavioural model.
module tb_barrel_arbiter;
  localparam int W = 32, N = 4, CW = 5, IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_ready, req_left;
  logic [N*W-1:0]  req_data;
  logic [N*CW-1:0] req_count;
  logic [N*2-1:0]  req_type;
  logic            resp_valid, resp_ready;
  logic [W-1:0]    resp_data;
  logic [IW-1:0]   resp_id;
`ifdef BARREL_ARB_LOCK_EN
  logic [N-1:0]    req_lock;
`endif

  barrel_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_count  (req_count),
    .req_left   (req_left),
    .req_type   (req_type),
`ifdef BARREL_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           id;
  } resp_t;

  resp_t sb[$];
  int    checks = 0, errors = 0;
  int    m_ptr = 0;
  bit    m_valid = 0;
  int    last_gnt = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bit position per iteration; rotate wraps, arithmetic right copies the sign.
  function automatic logic [W-1:0] model_shift(input logic [W-1:0] d, input int c,
                                               input bit left, input int t);
    logic [W-1:0] x;
    x = d;
    for (int n = 0; n < c; n++) begin
      if (left) x = (t == 0) ? {x[W-2:0], x[W-1]} : {x[W-2:0], 1'b0};
      else if (t == 0) x = {x[0], x[W-1:1]};
      else if (t == 2) x = {x[W-1], x[W-1:1]};
      else x = {1'b0, x[W-1:1]};
    end
    return x;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [W-1:0] d, input int c,
                         input bit l, input int t, input bit lk);
    req_valid[i]          = v;
    req_data[i*W +: W]    = d;
    req_count[i*CW +: CW] = CW'(c);
    req_left[i]           = l;
    req_type[i*2 +: 2]    = 2'(t);
`ifdef BARREL_ARB_LOCK_EN
    req_lock[i] = lk;
`else
    if (lk) ;
`endif
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 0, '0, 0, 0, 0, 0);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    int w;
    bit acc, lk;
    resp_t e;
    #2;
    check("resp_valid", resp_valid, m_valid);
    acc = !m_valid || resp_ready;
    w = -1;
    if (acc)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && req_valid[j]) w = j;
      end
    check("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
    if (acc) m_valid = (w >= 0);
    if (w >= 0) begin
      e.data = model_shift(req_data[w*W +: W], int'(req_count[w*CW +: CW]), req_left[w],
                           int'(req_type[w*2 +: 2]));
      e.id = w;
      sb.push_back(e);
`ifdef BARREL_ARB_LOCK_EN
      lk = req_lock[w];
`else
      lk = 0;
`endif
      m_ptr = lk ? w : (w + 1) % N;
    end
    last_gnt = w;
    @(negedge clk);
  endtask

  // Monitor: whenever a result is presented it must match the oldest expected one.
  initial forever begin
    @(negedge clk);
    #3;
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data %0h id %0d expected none", resp_data, resp_id);
      end else begin
        check("resp_data", resp_data, sb[0].data);
        check("resp_id", resp_id, sb[0].id);
        if (resp_ready) void'(sb.pop_front());
      end
    end
  end

  bit pend[N];

  initial begin
    rst = 1'b1;
    resp_ready = 1'b0;
    clear_reqs();
    req_valid = '1;
    #12;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_req_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_reqs();
    resp_ready = 1'b1;

    // Single left logical shift by one.
    set_req(0, 1, 32'd2, 1, 1, 1, 0);
    step();
    check("t1_valid", resp_valid, 1);
    check("t1_data", resp_data, 4);
    check("t1_id", resp_id, 0);

    // Back-to-back from two requesters.
    set_req(0, 1, 32'd2, 10, 1, 1, 0);
    step();
    check("t2a_data", resp_data, 2048);
    set_req(0, 0, '0, 0, 0, 0, 0);
    set_req(1, 1, 32'd24, 5, 0, 1, 0);
    step();
    check("t2b_data", resp_data, 0);
    check("t2b_id", resp_id, 1);

    // Stall with everyone pending, then release.
    for (int i = 0; i < N; i++) set_req(i, 1, $urandom, $urandom_range(0, 31), $urandom_range(0, 1),
                                        $urandom_range(0, 3), 0);
    step();
    resp_ready = 1'b0;
    repeat (3) step();
    check("t4_held_valid", resp_valid, 1);
    resp_ready = 1'b1;
    repeat (4) begin
      for (int i = 0; i < N; i++) if (last_gnt == i) set_req(i, 0, '0, 0, 0, 0, 0);
      step();
    end

    // Async reset while a result is held.
    set_req(2, 1, 32'h8000_0001, 3, 0, 2, 0);
    step();
    check("t5_pre_valid", resp_valid, 1);
    req_valid = '1;
    #1 rst = 1'b1;
    #1;
    check("t5_valid", resp_valid, 0);
    check("t5_data", resp_data, 0);
    check("t5_ready", req_ready, 0);
    sb.delete();
    m_valid = 0;
    m_ptr = 0;
    @(negedge clk);
    rst = 1'b0;

    // Round robin from a fresh pointer.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 1, $urandom, $urandom_range(0, 31),
                                          $urandom_range(0, 1), $urandom_range(0, 3), 0);
      step();
      check("t3_id", resp_id, c % N);
    end

`ifdef BARREL_ARB_LOCK_EN
    clear_reqs();
    set_req(1, 1, 32'd1, 0, 0, 1, 0);
    step();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 1, $urandom, $urandom_range(0, 31), 0, 1,
                                          (i == 2) && (c < 2));
      step();
      check("t6_id", resp_id, (c < 3) ? 2 : 3);
    end
`endif

    // Randomized traffic; pending requesters hold payload or withdraw.
    clear_reqs();
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else begin
          set_req(i, $urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 31),
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end
      end
      resp_ready = ($urandom_range(0, 9) < 7);
      step();
      for (int i = 0; i < N; i++) pend[i] = req_valid[i] && (last_gnt != i);
    end

    clear_reqs();
    resp_ready = 1'b1;
    repeat (3) step();
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
